// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter: independent read and write FSMs, each
// granting one outstanding transaction at a time with round-robin fairness.
module axi_rr_arbiter #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [N_MST-1:0]         m_arvalid,
    output logic [N_MST-1:0]         m_arready,
    input  logic [N_MST*ADDR_W-1:0]  m_araddr,
    output logic [N_MST-1:0]         m_rvalid,
    input  logic [N_MST-1:0]         m_rready,
    output logic [DATA_W-1:0]        m_rdata,
    output logic [N_MST-1:0]         m_rresp,

    input  logic [N_MST-1:0]         m_awvalid,
    output logic [N_MST-1:0]         m_awready,
    input  logic [N_MST*ADDR_W-1:0]  m_awaddr,
    input  logic [N_MST-1:0]         m_wvalid,
    output logic [N_MST-1:0]         m_wready,
    input  logic [N_MST*DATA_W-1:0]  m_wdata,
    input  logic [N_MST*MASK_W-1:0]  m_wmask,
    output logic [N_MST-1:0]         m_bvalid,
    input  logic [N_MST-1:0]         m_bready,
    output logic [N_MST-1:0]         m_bresp,

    output logic                     s_arvalid,
    input  logic                     s_arready,
    output logic [ADDR_W-1:0]        s_araddr,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    input  logic [DATA_W-1:0]        s_rdata,
    input  logic                     s_rresp,

    output logic                     s_awvalid,
    input  logic                     s_awready,
    output logic [ADDR_W-1:0]        s_awaddr,
    output logic                     s_wvalid,
    input  logic                     s_wready,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [MASK_W-1:0]        s_wmask,
    input  logic                     s_bvalid,
    output logic                     s_bready,
    input  logic                     s_bresp,

    output logic [N_MST-1:0]         rd_grant,
    output logic [N_MST-1:0]         wr_grant
);

    localparam int PTR_W = (N_MST > 1) ? $clog2(N_MST) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    rd_state_e        rd_state_q, rd_state_d;
    wr_state_e        wr_state_q, wr_state_d;
    logic [PTR_W-1:0] rd_sel_q, rd_sel_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_sel_q, wr_sel_d, wr_ptr_q, wr_ptr_d;

    // First requester at or after ptr, searching modulo N_MST.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_MST-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_MST; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_MST) idx = idx - N_MST;
            if (!found && req[idx]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_MST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rd_sel_q   <= '0;
            rd_ptr_q   <= '0;
            wr_sel_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_sel_q   <= rd_sel_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_sel_q   <= wr_sel_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Read next-state: a master dropping arvalid before the handshake is released.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (|m_arvalid) begin
                    rd_sel_d   = rr_pick(m_arvalid, rd_ptr_q);
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (!m_arvalid[rd_sel_q])
                    rd_state_d = R_IDLE;
                else if (s_arready)
                    rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (s_rvalid && m_rready[rd_sel_q]) begin
                    rd_state_d = R_IDLE;
                    rd_ptr_d   = ptr_inc(rd_sel_q);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_sel_d   = wr_sel_q;
        wr_ptr_d   = wr_ptr_q;
        case (wr_state_q)
            W_IDLE: begin
                if (|m_awvalid) begin
                    wr_sel_d   = rr_pick(m_awvalid, wr_ptr_q);
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (!m_awvalid[wr_sel_q])
                    wr_state_d = W_IDLE;
                else if (s_awready)
                    wr_state_d = W_DATA;
            end
            W_DATA: begin
                if (m_wvalid[wr_sel_q] && s_wready)
                    wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_bvalid && m_bready[wr_sel_q]) begin
                    wr_state_d = W_IDLE;
                    wr_ptr_d   = ptr_inc(wr_sel_q);
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign m_rdata = s_rdata;

    // Outputs are forced low while reset is held, even before the state flops clear.
    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rresp   = '0;
        rd_grant  = '0;
        if (!reset) begin
            if (rd_state_q != R_IDLE) rd_grant[rd_sel_q] = 1'b1;
            case (rd_state_q)
                R_ADDR: begin
                    s_arvalid           = m_arvalid[rd_sel_q];
                    s_araddr            = m_araddr[int'(rd_sel_q)*ADDR_W +: ADDR_W];
                    m_arready[rd_sel_q] = s_arready;
                end
                R_DATA: begin
                    m_rvalid[rd_sel_q] = s_rvalid;
                    m_rresp[rd_sel_q]  = s_rresp;
                    s_rready           = m_rready[rd_sel_q];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wmask   = '0;
        s_bready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        wr_grant  = '0;
        if (!reset) begin
            if (wr_state_q != W_IDLE) wr_grant[wr_sel_q] = 1'b1;
            case (wr_state_q)
                W_ADDR: begin
                    s_awvalid           = m_awvalid[wr_sel_q];
                    s_awaddr            = m_awaddr[int'(wr_sel_q)*ADDR_W +: ADDR_W];
                    m_awready[wr_sel_q] = s_awready;
                end
                W_DATA: begin
                    s_wvalid           = m_wvalid[wr_sel_q];
                    s_wdata            = m_wdata[int'(wr_sel_q)*DATA_W +: DATA_W];
                    s_wmask            = m_wmask[int'(wr_sel_q)*MASK_W +: MASK_W];
                    m_wready[wr_sel_q] = s_wready;
                end
                W_RESP: begin
                    m_bvalid[wr_sel_q] = s_bvalid;
                    m_bresp[wr_sel_q]  = s_bresp;
                    s_bready           = m_bready[wr_sel_q];
                end
                default: ;
            endcase
        end
    end

endmodule
